// File: rtl/issue_scoreboard.sv
// issue_scoreboard: issue controller between the decoder and the execute stage.
// Tracks registers that have writes in flight and stalls RAW/WAW hazards. It also
// serialises the single non-pipelined F unit and holds each issued operation in a
// one-entry valid/ready output slot.
// Optional feature: define ISSUE_STALL_CNT_EN to add a saturating stall_cnt output.
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic            f_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_f,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            wb_f,
    input  logic            flush,
    output logic [NREG-1:0] pending,
`ifdef ISSUE_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic            stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            stall_reg;
    logic            out_valid_reg;
    logic [4:0]      out_rd_reg;
    logic            out_f_reg;
    logic            f_busy_reg;
    logic            f_busy_next;
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] eff_pending;
    logic            hazard;
    logic            f_block;
    logic            accept;

    // Per-register view: the writeback clear is visible in the same cycle, an accept
    // of the same rd wins over that clear, and register 0 is never tracked.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign eff_pending[gi]  = 1'b0;
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                assign eff_pending[gi]  = pending_reg[gi] & ~(wb_valid && (wb_rd == 5'(gi)));
                assign pending_next[gi] = flush ? 1'b0
                                        : (accept && (rd == 5'(gi))) ? 1'b1
                                        : eff_pending[gi];
            end
        end
    endgenerate

    assign hazard   = eff_pending[rs1] | eff_pending[rs2] | eff_pending[rd];
    // An F writeback in this cycle frees the unit for an F op accepted in the same cycle.
    assign f_block  = f_en & f_busy_reg & ~(wb_valid & wb_f);
    assign in_ready = (state_reg != FLUSH) & ~flush & (~out_valid_reg | out_ready)
                    & ~hazard & ~f_block;
    assign accept   = in_valid & in_ready;

    // An accept re-arms f_busy even if an F writeback clears it in the same cycle.
    always_comb begin
        f_busy_next = f_busy_reg;
        if (flush)
            f_busy_next = 1'b0;
        else if (accept && f_en)
            f_busy_next = 1'b1;
        else if (wb_valid && wb_f)
            f_busy_next = 1'b0;
    end

    // Next-state logic for the issue FSM; flush overrides every state.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            case (state_reg)
                IDLE:    if (in_valid) state_next = RUN;
                RUN:     if (!in_valid) state_next = IDLE;
                         else if (!in_ready) state_next = STALL;
                STALL:   if (!in_valid) state_next = IDLE;
                         else if (in_ready) state_next = RUN;
                FLUSH:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state and registered stall flag, which tracks the state it will be in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            stall_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            stall_reg <= (state_next == STALL);
        end
    end

    // Output slot, scoreboard vector and F-unit busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_rd_reg    <= '0;
            out_f_reg     <= 1'b0;
            pending_reg   <= '0;
            f_busy_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            f_busy_reg  <= f_busy_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                out_rd_reg    <= rd;
                out_f_reg     <= f_en;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Saturating count of cycles an instruction waited; survives flush.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (in_valid && !in_ready && !flush && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign stall_cnt = stall_cnt_reg;
`endif

    assign out_valid = out_valid_reg;
    assign out_rd    = out_rd_reg;
    assign out_f     = out_f_reg;
    assign pending   = pending_reg;
    assign stall     = stall_reg;

endmodule
